// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the N-port CPU memory arbiter: FSM encodings and
// well-known requester port indices.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_GRANT   = 2'b01,
        ST_RELEASE = 2'b10
    } state_t;

    localparam int PORT_INSTR = 0;
    localparam int PORT_DATA  = 1;

endpackage

// File: rtl/rr_priority_select.sv
// Combinational winner selection: first requesting port found searching upward
// from a start index with wrap; fixed mode always starts at the instruction port.
module rr_priority_select
    import cpu_mem_pkg::*;
#(
    parameter int NPORTS = 4,
    parameter int PTR_W  = $clog2(NPORTS)
) (
    input  logic [NPORTS-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    input  logic              rr_mode,
    output logic [NPORTS-1:0] winner,
    output logic [PTR_W-1:0]  winner_idx
);

    logic [PTR_W-1:0] start;
    logic             found;
    int               idx;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        idx        = 0;
        start      = rr_mode ? ptr : PTR_W'(PORT_INSTR);
        for (int k = 0; k < NPORTS; k++) begin
            idx = int'(start) + k;
            if (idx >= NPORTS) idx = idx - NPORTS;
            if (!found && req[idx]) begin
                found       = 1'b1;
                winner[idx] = 1'b1;
                winner_idx  = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/cpu_memory_arbiter_nport.sv
// Arbitrates NPORTS requesters onto one valid/ready memory bus with burst hold,
// a per-grant beat cap, a one-cycle release gap and tagged read-data return.
module cpu_memory_arbiter_nport
    import cpu_mem_pkg::*;
#(
    parameter int NPORTS    = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int RR_MODE   = 1,
    parameter int MAX_BURST = 8
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [NPORTS-1:0]          req_valid,
    input  logic [NPORTS-1:0]          req_wr,
    input  logic [NPORTS*ADDR_W-1:0]   req_addr,
    input  logic [NPORTS*DATA_W-1:0]   req_wdata,
    output logic [NPORTS-1:0]          req_ready,
    output logic [DATA_W-1:0]          rdata,
    output logic [NPORTS-1:0]          rdata_valid,
    output logic [ADDR_W-1:0]          mem_address,
    output logic [DATA_W-1:0]          mem_data_out,
    output logic                       mem_wr,
    output logic                       mem_valid,
    input  logic                       mem_ready,
    input  logic [DATA_W-1:0]          mem_data_in
);

    localparam int PTR_W = $clog2(NPORTS);

    state_t              state, state_nxt;
    logic [NPORTS-1:0]   grant;
    logic [PTR_W-1:0]    g;
    logic [PTR_W-1:0]    rr_ptr;
    logic [7:0]          beat_cnt;
    logic                rd_pend;
    logic [NPORTS-1:0]   rd_tag;
    logic [NPORTS-1:0]   win;
    logic [PTR_W-1:0]    win_idx;
    logic                accept;
    logic                release_now;

    rr_priority_select #(
        .NPORTS (NPORTS),
        .PTR_W  (PTR_W)
    ) u_select (
        .req        (req_valid),
        .ptr        (rr_ptr),
        .rr_mode    (RR_MODE != 0),
        .winner     (win),
        .winner_idx (win_idx)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        mem_valid    = 1'b0;
        mem_wr       = 1'b0;
        mem_address  = '0;
        mem_data_out = '0;
        req_ready    = '0;
        accept       = 1'b0;
        release_now  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|req_valid) state_nxt = ST_GRANT;
            end
            ST_GRANT: begin
                mem_valid    = req_valid[g];
                mem_wr       = req_wr[g];
                mem_address  = req_addr[g*ADDR_W +: ADDR_W];
                mem_data_out = req_wdata[g*DATA_W +: DATA_W];
                accept       = mem_valid & mem_ready;
                req_ready[g] = accept;
                // Cap check uses the post-increment count of this beat.
                release_now  = !req_valid[g] ||
                               (accept && (beat_cnt + 8'd1 == 8'(MAX_BURST)));
                if (release_now) state_nxt = ST_RELEASE;
            end
            ST_RELEASE: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            grant    <= '0;
            g        <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            rd_pend  <= 1'b0;
            rd_tag   <= '0;
        end else begin
            // Tag follows the accepted read so its data lands one cycle later,
            // even if the grant is already being released.
            rd_pend <= accept & ~mem_wr;
            rd_tag  <= grant;
            case (state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        grant <= win;
                        g     <= win_idx;
                    end
                end
                ST_GRANT: begin
                    if (accept) beat_cnt <= beat_cnt + 8'd1;
                    if (release_now) begin
                        grant  <= '0;
                        rr_ptr <= (g == PTR_W'(NPORTS-1)) ? '0 : g + PTR_W'(1);
                    end
                end
                ST_RELEASE: beat_cnt <= '0;
                default: ;
            endcase
        end
    end

    assign rdata_valid = rd_pend ? rd_tag : '0;
    assign rdata       = rd_pend ? mem_data_in : '0;

endmodule

// File: tb/tb_cpu_memory_arbiter_nport.sv
// Directed bench: a per-port beat-queue requester and a simple memory drive a
// round-robin and a fixed-priority arbiter; beat and read-return logs are checked.
module tb_cpu_memory_arbiter_nport;
    import cpu_mem_pkg::*;

    localparam int NP = 4;
    localparam int AW = 16;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NP-1:0]    req_valid, req_wr;
    logic [NP*AW-1:0] req_addr;
    logic [NP*DW-1:0] req_wdata;
    logic             mem_ready;
    logic [DW-1:0]    mem_data_in;
    logic             sel;

    logic [NP-1:0] ready_r, rv_r, ready_f, rv_f;
    logic [DW-1:0] rdata_r, mdo_r, rdata_f, mdo_f;
    logic [AW-1:0] maddr_r, maddr_f;
    logic          mwr_r, mval_r, mwr_f, mval_f;

    cpu_memory_arbiter_nport #(.NPORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .MAX_BURST(8)) dut_rr (
        .CLK(clk), .RST(rst), .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(ready_r), .rdata(rdata_r), .rdata_valid(rv_r),
        .mem_address(maddr_r), .mem_data_out(mdo_r), .mem_wr(mwr_r), .mem_valid(mval_r),
        .mem_ready(mem_ready & ~sel), .mem_data_in(mem_data_in));

    cpu_memory_arbiter_nport #(.NPORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .MAX_BURST(8)) dut_fx (
        .CLK(clk), .RST(rst), .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(ready_f), .rdata(rdata_f), .rdata_valid(rv_f),
        .mem_address(maddr_f), .mem_data_out(mdo_f), .mem_wr(mwr_f), .mem_valid(mval_f),
        .mem_ready(mem_ready & sel), .mem_data_in(mem_data_in));

    logic [NP-1:0] req_ready, rdata_valid;
    logic [DW-1:0] rdata, mem_data_out;
    logic [AW-1:0] mem_address;
    logic          mem_wr, mem_valid;
    assign req_ready    = sel ? ready_f : ready_r;
    assign rdata_valid  = sel ? rv_f    : rv_r;
    assign rdata        = sel ? rdata_f : rdata_r;
    assign mem_data_out = sel ? mdo_f   : mdo_r;
    assign mem_address  = sel ? maddr_f : maddr_r;
    assign mem_wr       = sel ? mwr_f   : mwr_r;
    assign mem_valid    = sel ? mval_f  : mval_r;

    logic [15:0] mem [logic [15:0]];

    logic [15:0] q_addr [NP][16];
    logic [15:0] q_data [NP][16];
    logic        q_wr   [NP][16];
    int          q_head [NP];
    int          q_tail [NP];

    int          n_b, n_r, cyc;
    int          b_port [64];
    int          b_cyc  [64];
    logic [15:0] b_addr [64];
    logic [15:0] b_data [64];
    logic        b_wr   [64];
    int          r_port [64];
    int          r_cyc  [64];
    logic [15:0] r_data [64];
    logic        mv_hist [1024];

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int p, input logic wr, input logic [15:0] a, input logic [15:0] d);
        q_addr[p][q_tail[p]] = a;
        q_data[p][q_tail[p]] = d;
        q_wr[p][q_tail[p]]   = wr;
        q_tail[p]++;
    endtask

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            if (q_head[p] < q_tail[p]) begin
                req_valid[p]           = 1'b1;
                req_wr[p]              = q_wr[p][q_head[p]];
                req_addr[p*AW +: AW]   = q_addr[p][q_head[p]];
                req_wdata[p*DW +: DW]  = q_data[p][q_head[p]];
            end else begin
                req_valid[p]           = 1'b0;
                req_wr[p]              = 1'b0;
                req_addr[p*AW +: AW]   = '0;
                req_wdata[p*DW +: DW]  = '0;
            end
        end
    endtask

    task automatic flush_queues();
        for (int p = 0; p < NP; p++) begin
            q_head[p] = 0;
            q_tail[p] = 0;
        end
        drive();
    endtask

    task automatic clear_log();
        n_b = 0;
        n_r = 0;
        for (int i = 0; i < 64; i++) begin
            b_port[i] = -1; b_cyc[i] = -1; b_addr[i] = 'x; b_data[i] = 'x; b_wr[i] = 1'bx;
            r_port[i] = -1; r_cyc[i] = -1; r_data[i] = 'x;
        end
    endtask

    // One clock: sample at the falling edge, then advance requesters and memory.
    task automatic step();
        logic [NP-1:0] acc;
        logic          do_mem, mw;
        logic [15:0]   ma, md;
        @(negedge clk);
        if (cyc < 1024) mv_hist[cyc] = mem_valid;
        acc    = req_ready;
        do_mem = mem_valid & mem_ready;
        mw     = mem_wr;
        ma     = mem_address;
        md     = mem_data_out;
        for (int p = 0; p < NP; p++) begin
            if (acc[p] && n_b < 64) begin
                b_port[n_b] = p; b_cyc[n_b] = cyc; b_addr[n_b] = mem_address;
                b_data[n_b] = mem_data_out; b_wr[n_b] = mem_wr;
                n_b++;
            end
        end
        if (rdata_valid != '0 && n_r < 64) begin
            for (int p = NP-1; p >= 0; p--) if (rdata_valid[p]) r_port[n_r] = p;
            r_cyc[n_r]  = cyc;
            r_data[n_r] = rdata;
            n_r++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (do_mem) begin
            if (mw) mem[ma] = md;
            else    mem_data_in = mem.exists(ma) ? mem[ma] : 16'h0000;
        end
        for (int p = 0; p < NP; p++) if (acc[p]) q_head[p]++;
        drive();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic drain(input int maxc);
        int  c;
        logic busy;
        c = 0;
        busy = 1'b1;
        while (busy && c < maxc) begin
            step();
            c++;
            busy = 1'b0;
            for (int p = 0; p < NP; p++) if (q_head[p] < q_tail[p]) busy = 1'b1;
        end
        chk("drain_timeout", {31'd0, busy}, 32'd0);
        run(4);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_req_ready"},   {28'd0, req_ready},   32'd0);
        chk({tag, "_rdata_valid"}, {28'd0, rdata_valid}, 32'd0);
        chk({tag, "_mem_valid"},   {31'd0, mem_valid},   32'd0);
        chk({tag, "_mem_wr"},      {31'd0, mem_wr},      32'd0);
        chk({tag, "_mem_address"}, {16'd0, mem_address}, 32'd0);
        chk({tag, "_mem_data_out"},{16'd0, mem_data_out},32'd0);
        chk({tag, "_rdata"},       {16'd0, rdata},       32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int c;
        sel = 1'b0; rst = 1'b1; mem_ready = 1'b1; mem_data_in = '0; cyc = 0;
        req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
        mem[16'h0010] = 16'h1234;
        for (int k = 0; k < 12; k++) mem[16'h0100 + 16'(2*k)] = 16'hA000 + 16'(k);
        mem[16'h0200] = 16'h0000;
        flush_queues();
        clear_log();

        // Reset state, with a request already pending on a port.
        push(1, 1'b1, 16'h0055, 16'h7777);
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        flush_queues();
        @(posedge clk); #1;
        rst = 1'b0;

        // Single read on the data port.
        clear_log();
        t = cyc;
        push(PORT_DATA, 1'b0, 16'h0010, 16'h0000);
        drive();
        drain(20);
        chk("t1_mv_decision", {31'd0, mv_hist[t]},   32'd0);
        chk("t1_mv_grant",    {31'd0, mv_hist[t+1]}, 32'd1);
        chk("t1_nbeats",      n_b, 1);
        chk("t1_port",        b_port[0], PORT_DATA);
        chk("t1_addr",        {16'd0, b_addr[0]}, 32'h0010);
        chk("t1_beat_cyc",    b_cyc[0], t + 1);
        chk("t1_nret",        n_r, 1);
        chk("t1_ret_port",    r_port[0], 1);
        chk("t1_rdata",       {16'd0, r_data[0]}, 32'h1234);
        chk("t1_ret_cyc",     r_cyc[0], t + 2);

        // Write then read-back in one burst.
        clear_log();
        push(1, 1'b1, 16'h0200, 16'hBEEF);
        push(1, 1'b0, 16'h0200, 16'h0000);
        drive();
        drain(20);
        chk("t5_nbeats",   n_b, 2);
        chk("t5_wr",       {31'd0, b_wr[0]}, 32'd1);
        chk("t5_waddr",    {16'd0, b_addr[0]}, 32'h0200);
        chk("t5_wdata",    {16'd0, b_data[0]}, 32'hBEEF);
        chk("t5_rd",       {31'd0, b_wr[1]}, 32'd0);
        chk("t5_nret",     n_r, 1);
        chk("t5_ret_port", r_port[0], 1);
        chk("t5_readback", {16'd0, r_data[0]}, 32'hBEEF);
        chk("t5_ret_cyc",  r_cyc[0], b_cyc[1] + 1);

        // Bring rr_ptr to 1 by serving port 0 alone.
        push(0, 1'b0, 16'h0010, 16'h0000);
        drive();
        drain(20);

        // Ports 0 and 2 together with rr_ptr=1: port 2 first.
        clear_log();
        push(0, 1'b0, 16'h0100, 16'h0000);
        push(2, 1'b0, 16'h0102, 16'h0000);
        drive();
        drain(30);
        chk("t2_nbeats", n_b, 2);
        chk("t2_first",  b_port[0], 2);
        chk("t2_second", b_port[1], 0);
        chk("t2_gap",    b_cyc[1] - b_cyc[0], 4);
        chk("t2_rd0",    {16'd0, r_data[0]}, 32'hA001);
        chk("t2_rd1",    {16'd0, r_data[1]}, 32'hA000);

        // rr_ptr now 1: ports 0 and 1 together, port 1 first.
        clear_log();
        push(0, 1'b0, 16'h0010, 16'h0000);
        push(1, 1'b0, 16'h0102, 16'h0000);
        drive();
        drain(30);
        chk("t2b_first",  b_port[0], 1);
        chk("t2b_second", b_port[1], 0);

        // Burst cap with port 3 waiting.
        clear_log();
        for (int k = 0; k < 12; k++) push(0, 1'b0, 16'h0100 + 16'(2*k), 16'h0000);
        drive();
        run(2);
        push(3, 1'b0, 16'h0010, 16'h0000);
        drive();
        drain(80);
        chk("t4_nbeats", n_b, 13);
        for (int k = 0; k < 8; k++) begin
            chk("t4_cap_port", b_port[k], 0);
            chk("t4_cap_addr", {16'd0, b_addr[k]}, 32'h0100 + 32'(2*k));
        end
        chk("t4_mv_release", {31'd0, mv_hist[b_cyc[7]+1]}, 32'd0);
        chk("t4_p3_port",    b_port[8], 3);
        chk("t4_p3_gap",     b_cyc[8] - b_cyc[7], 3);
        for (int k = 9; k < 13; k++) begin
            chk("t4_resume_port", b_port[k], 0);
            chk("t4_resume_addr", {16'd0, b_addr[k]}, 32'h0110 + 32'(2*(k-9)));
        end
        chk("t4_nret",        n_r, 13);
        chk("t4_ret7_data",   {16'd0, r_data[7]}, 32'hA007);
        chk("t4_ret7_cyc",    r_cyc[7], b_cyc[7] + 1);
        chk("t4_ret8_port",   r_port[8], 3);
        chk("t4_ret8_data",   {16'd0, r_data[8]}, 32'h1234);
        chk("t4_ret12_data",  {16'd0, r_data[12]}, 32'hA00B);

        // Fixed-priority instance.
        rst = 1'b1;
        flush_queues();
        @(posedge clk); #1;
        rst = 1'b0;
        sel = 1'b1;
        clear_log();
        push(0, 1'b0, 16'h0100, 16'h0000);
        push(2, 1'b0, 16'h0102, 16'h0000);
        drive();
        drain(30);
        chk("t3_first",  b_port[0], 0);
        chk("t3_second", b_port[1], 2);

        clear_log();
        for (int k = 0; k < 9; k++) push(0, 1'b0, 16'h0100 + 16'(2*k), 16'h0000);
        push(1, 1'b0, 16'h0010, 16'h0000);
        drive();
        drain(60);
        chk("t3_nbeats",    n_b, 10);
        chk("t3_rewin",     b_port[8], 0);
        chk("t3_rewin_gap", b_cyc[8] - b_cyc[7], 3);
        chk("t3_last",      b_port[9], 1);

        // Reset in the middle of a burst, with a read return pending.
        rst = 1'b1;
        flush_queues();
        @(posedge clk); #1;
        rst = 1'b0;
        sel = 1'b0;
        clear_log();
        for (int k = 0; k < 6; k++) push(2, 1'b0, 16'h0100 + 16'(2*k), 16'h0000);
        drive();
        c = 0;
        while (n_b < 3 && c < 20) begin
            step();
            c++;
        end
        chk("t6_beats_before_rst", n_b, 3);
        rst = 1'b1;
        #1;
        check_idle_outputs("t6_rst");
        flush_queues();
        @(posedge clk); #1;
        rst = 1'b0;
        clear_log();
        push(1, 1'b0, 16'h0010, 16'h0000);
        push(3, 1'b0, 16'h0102, 16'h0000);
        drive();
        drain(30);
        chk("t6_first",  b_port[0], 1);
        chk("t6_second", b_port[1], 3);
        chk("t6_nret",   n_r, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
